// File: rtl/mul_booth_seq_ctrl.sv
// mul_booth_seq_ctrl
//   Multi-cycle sequencer for the radix-4 Booth multiply datapath (MUL op).
//   One signed WIDTH x WIDTH request is latched on accept. The sequencer runs
//   WIDTH/2 registered Booth bit-pair steps and then presents the 2*WIDTH-bit
//   product on prod/hi/lo. done and hilo_wr pulse together for one cycle.
//
//   Optional feature macro: MUL_EARLY_TERM_EN
//     When defined, the sequencer goes to a FINISH state as soon as the
//     remaining multiplier bits can only contribute "+0" steps. FINISH then
//     collapses those steps into one arithmetic shift. The product is the same,
//     but latency varies from 2 to WIDTH/2 cycles after accept.
//     When undefined, latency is fixed at WIDTH/2 cycles and there is no shifter.
module mul_booth_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic [WIDTH-1:0]   Q,
   input  logic [WIDTH-1:0]   M,
   output logic               busy,
   output logic               done,
   output logic               hilo_wr,
   output logic [2*WIDTH-1:0] prod,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   localparam int HALF = WIDTH / 2;
   localparam int PW   = 2 * WIDTH;
   localparam int SW   = WIDTH + 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
`ifdef MUL_EARLY_TERM_EN
      S_FINISH,
`endif
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [SW-1:0]    upper;
   logic [SW-1:0]    q_ext;
   logic [SW-1:0]    q2_ext;
   logic [SW-1:0]    sum;
   logic [PW-1:0]    step_acc;

   // One Booth bit-pair step: recode {acc[1:0],carry}, add to the sign-extended upper half, shift right by 2.
   always_comb begin
      upper  = {{2{acc_q[PW-1]}}, acc_q[PW-1:WIDTH]};
      q_ext  = {{2{q_q[WIDTH-1]}}, q_q};
      q2_ext = {q_q[WIDTH-1], q_q, 1'b0};
      unique case ({acc_q[1:0], carry_q})
         3'b001, 3'b010: sum = upper + q_ext;
         3'b011:         sum = upper + q2_ext;
         3'b100:         sum = upper - q2_ext;
         3'b101, 3'b110: sum = upper - q_ext;
         default:        sum = upper;
      endcase
      step_acc = {sum, acc_q[WIDTH-1:2]};
   end

`ifdef MUL_EARLY_TERM_EN
   logic [CNT_W+1:0] chk_shamt;
   logic [CNT_W+1:0] fin_shamt;
   logic [WIDTH-1:0] rem_mask;
   logic [WIDTH-1:0] rem_bits;
   logic             early_ok;
   logic [PW-1:0]    fin_acc;

   // Early exit when the unprocessed multiplier bits and the carry all agree; FINISH then shifts out the skipped steps.
   always_comb begin
      chk_shamt = {({1'b0, cnt_q} + (CNT_W+1)'(1)), 1'b0};
      rem_mask  = {WIDTH{1'b1}} >> chk_shamt;
      rem_bits  = step_acc[WIDTH-1:0];
      early_ok  = (((rem_bits & rem_mask) == '0) && !acc_q[1]) ||
                  (((rem_bits | ~rem_mask) == '1) && acc_q[1]);
      fin_shamt = {((CNT_W+1)'(HALF) - {1'b0, cnt_q}), 1'b0};
      fin_acc   = $signed(acc_q) >>> fin_shamt;
   end
`endif

   // Next-state and datapath control for the sequencer.
   always_comb begin
      // NOTE: every _d defaults to its _q (strobes default low), so no path through this block infers a latch.
      state_d = state_q;
      acc_d   = acc_q;
      q_d     = q_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               q_d     = Q;
               acc_d   = {{WIDTH{1'b0}}, M};
               carry_d = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            acc_d   = step_acc;
            carry_d = acc_q[1];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(HALF - 1)) begin
               prod_d  = step_acc;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
`ifdef MUL_EARLY_TERM_EN
            else if (early_ok) begin
               busy_d  = 1'b1;
               state_d = S_FINISH;
            end
`endif
            else begin
               busy_d = 1'b1;
            end
         end
`ifdef MUL_EARLY_TERM_EN
         S_FINISH: begin
            prod_d  = fin_acc;
            done_d  = 1'b1;
            state_d = S_DONE;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register; clr abandons any running op and clears every flop, including prod.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
      if (clr) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         q_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         prod_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign hilo_wr = done_q;
   assign prod    = prod_q;
   assign hi      = prod_q[PW-1:WIDTH];
   assign lo      = prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_mul_booth_seq_ctrl.sv
// tb_mul_booth_seq_ctrl
//   Directed bench for the radix-4 Booth multiply sequencer. Expected latencies
//   depend on whether MUL_EARLY_TERM_EN is defined.
`timescale 1ns/1ps
module tb_mul_booth_seq_ctrl;

   localparam int WIDTH = 32;
`ifdef MUL_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic              clk;
   logic              clr;
   logic              start;
   logic [WIDTH-1:0]  q;
   logic [WIDTH-1:0]  m;
   logic              busy;
   logic              done;
   logic              hilo_wr;
   logic [63:0]       prod;
   logic [WIDTH-1:0]  hi;
   logic [WIDTH-1:0]  lo;

   int checks = 0;
   int errors = 0;

   mul_booth_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clk     (clk),
      .clr     (clr),
      .start   (start),
      .Q       (q),
      .M       (m),
      .busy    (busy),
      .done    (done),
      .hilo_wr (hilo_wr),
      .prod    (prod),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one op (accepted at E0) and wait up to 40 edges for done.
   // If inj_cyc > 0, a stray start with Q=M=9 is driven into edge E<inj_cyc>.
   // Q/M are scrambled right after accept. lat = edges from accept to done (0 = timeout).
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inj_cyc,
                         output int lat, output int busy_cnt, output bit wr_ok);
      lat      = 0;
      busy_cnt = 0;
      wr_ok    = 1'b1;
      @(posedge clk); #1;
      q = a; m = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      q = ~a; m = ~b;
      if (busy === 1'b1) busy_cnt++;
      if (hilo_wr !== done) wr_ok = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc == inj_cyc) begin
            start = 1'b1; q = 32'd9; m = 32'd9;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (hilo_wr !== done) wr_ok = 1'b0;
         if (done === 1'b1) begin
            lat = cyc;
            break;
         end
         if (busy === 1'b1) busy_cnt++;
      end
   endtask

   task automatic test_reset;
      clr = 1'b1; start = 1'b0; q = '0; m = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hilo_wr !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl busy=%b done=%b hilo_wr=%b required 0 0 0", busy, done, hilo_wr);
      end
      checks++;
      if (prod !== 64'd0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++;
         $display("FAIL reset_prod prod=%h hi=%h lo=%h required all zero", prod, hi, lo);
      end
      clr = 1'b0;
   endtask

   task automatic test_basic;
      int lat, bc;
      bit wr_ok;
      int exp_lat = EARLY ? 3 : 16;
      run_op(32'd2, 32'd5, 0, lat, bc, wr_ok);
      checks++;
      if (lat != exp_lat) begin
         errors++; $display("FAIL basic_latency got %0d required %0d", lat, exp_lat);
      end
      checks++;
      if (prod !== 64'd10) begin
         errors++; $display("FAIL basic_prod got %h required %h", prod, 64'd10);
      end
      checks++;
      if (hi !== 32'h0 || lo !== 32'h0000000A) begin
         errors++; $display("FAIL basic_hilo hi=%h lo=%h required 00000000 0000000a", hi, lo);
      end
      checks++;
      if (!wr_ok || hilo_wr !== 1'b1) begin
         errors++; $display("FAIL basic_hilo_wr tracking=%b hilo_wr=%b required 1 1", wr_ok, hilo_wr);
      end
      checks++;
      if (bc != exp_lat) begin
         errors++; $display("FAIL basic_busy_cycles got %0d required %0d", bc, exp_lat);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || hilo_wr !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_done_pulse done=%b hilo_wr=%b busy=%b required 0 0 0", done, hilo_wr, busy);
      end
   endtask

   // Table of signed vectors: product, hi/lo split and latency per build.
   task automatic run_table(input string tag, input int n,
                            input logic [31:0] qa [8], input logic [31:0] ma [8],
                            input logic [63:0] pa [8], input int la [8]);
      int lat, bc;
      bit wr_ok;
      logic [63:0] exp_p;
      for (int i = 0; i < n; i++) begin
         exp_p = pa[i];
         run_op(qa[i], ma[i], 0, lat, bc, wr_ok);
         checks++;
         if (prod !== exp_p || hi !== exp_p[63:32] || lo !== exp_p[31:0]) begin
            errors++;
            $display("FAIL %s_prod[%0d] prod=%h hi=%h lo=%h required %h", tag, i, prod, hi, lo, exp_p);
         end
         checks++;
         if (lat != la[i] || !wr_ok) begin
            errors++;
            $display("FAIL %s_latency[%0d] got %0d (hilo_wr ok=%b) required %0d", tag, i, lat, wr_ok, la[i]);
         end
      end
   endtask

   task automatic test_signed;
      logic [31:0] qa [8] = '{32'hFFFFFFFE, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0};
      logic [31:0] ma [8] = '{32'd5, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0};
      logic [63:0] pa [8] = '{64'hFFFFFFFFFFFFFFF6, 64'h3FFFFFFF00000001, 0, 0, 0, 0, 0, 0};
      int          la [8] = '{EARLY ? 3 : 16, 16, 0, 0, 0, 0, 0, 0};
      run_table("signed", 2, qa, ma, pa, la);
   endtask

   task automatic test_extremes;
      logic [31:0] qa [8] = '{32'h80000000, 32'h80000000, 0, 0, 0, 0, 0, 0};
      logic [31:0] ma [8] = '{32'h80000000, 32'd1, 0, 0, 0, 0, 0, 0};
      logic [63:0] pa [8] = '{64'h4000000000000000, 64'hFFFFFFFF80000000, 0, 0, 0, 0, 0, 0};
      int          la [8] = '{16, EARLY ? 2 : 16, 0, 0, 0, 0, 0, 0};
      run_table("extreme", 2, qa, ma, pa, la);
   endtask

   task automatic test_ignore_start;
      int lat, bc;
      bit wr_ok;
      bit stray;
      int inj = EARLY ? 2 : 5;
      run_op(32'd3, 32'd7, inj, lat, bc, wr_ok);
      checks++;
      if (prod !== 64'd21 || lat != (EARLY ? 3 : 16)) begin
         errors++; $display("FAIL ignore_mid prod=%h lat=%0d required %h %0d", prod, lat, 64'd21, EARLY ? 3 : 16);
      end
      // Stray start during the DONE cycle must not be accepted.
      start = 1'b1; q = 32'd9; m = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL ignore_done busy=%b done=%b required 0 0", busy, done);
      end
      stray = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
      end
      checks++;
      if (stray || prod !== 64'd21) begin
         errors++; $display("FAIL ignore_single stray=%b prod=%h required 0 %h", stray, prod, 64'd21);
      end
      run_op(32'd9, 32'd9, 0, lat, bc, wr_ok);
      checks++;
      if (prod !== 64'd81 || lat != (EARLY ? 4 : 16)) begin
         errors++; $display("FAIL ignore_reaccept prod=%h lat=%0d required %h %0d", prod, lat, 64'd81, EARLY ? 4 : 16);
      end
   endtask

   task automatic test_clr_abort;
      int lat, bc;
      bit wr_ok;
      bit saw_done = 1'b0;
      int clr_cyc = EARLY ? 2 : 8;
      @(posedge clk); #1;
      q = 32'd6; m = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= clr_cyc; cyc++) begin
         if (cyc == clr_cyc) clr = 1'b1;
         @(posedge clk); #1;
         if (done !== 1'b0) saw_done = 1'b1;
      end
      clr = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || prod !== 64'd0) begin
         errors++; $display("FAIL abort_state busy=%b done=%b prod=%h required 0 0 0", busy, done, prod);
      end
      repeat (20) begin
         @(posedge clk); #1;
         if (done !== 1'b0) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++; $display("FAIL abort_no_done saw_done=%b required 0", saw_done);
      end
      run_op(32'd4, 32'd4, 0, lat, bc, wr_ok);
      checks++;
      if (prod !== 64'd16 || lat != (EARLY ? 3 : 16)) begin
         errors++; $display("FAIL abort_restart prod=%h lat=%0d required %h %0d", prod, lat, 64'd16, EARLY ? 3 : 16);
      end
   endtask

   task automatic test_vectors;
      logic [31:0] qa [8] = '{32'd3, 32'd5, 32'd7, 32'd0, 32'hFFFFFFF9, 32'h12345678, 32'hFFFFFFFF, 32'h7FFFFFFF};
      logic [31:0] ma [8] = '{32'd1, 32'hFFFFFFFF, 32'h40000000, 32'd0, 32'hFFFFFFFD, 32'h10, 32'hFFFFFFFF, 32'h80000000};
      logic [63:0] pa [8] = '{64'd3, 64'hFFFFFFFFFFFFFFFB, 64'h00000001C0000000, 64'd0,
                              64'd21, 64'h0000000123456780, 64'd1, 64'hC000000080000000};
      int          la [8] = '{EARLY ? 2 : 16, EARLY ? 2 : 16, 16, EARLY ? 2 : 16,
                              EARLY ? 3 : 16, EARLY ? 4 : 16, EARLY ? 2 : 16, 16};
      run_table("vec", 8, qa, ma, pa, la);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_extremes();
      test_ignore_start();
      test_clr_abort();
      test_vectors();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
